// File: rtl/gpio_in_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_in_capture_pkg
//  Description : Shared definitions for the GPIO input capture block:
//                settings-bus register offsets, debounce counter width and
//                an address helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpio_in_capture_pkg;

    // Register offsets relative to the block's settings-bus base address
    localparam int GPIO_IN_RISE = 0;
    localparam int GPIO_IN_FALL = 1;
    localparam int GPIO_IN_DB   = 2;
    localparam int GPIO_IN_CLR  = 3;

    // Width of the debounce stable-time counter
    localparam int DB_W = 16;

    typedef logic [DB_W-1:0] db_cnt_t;

    // Absolute 8-bit settings-bus address of a register
    function automatic logic [7:0] reg_addr(input int base, input int offset);
        return 8'(base + offset);
    endfunction

endpackage : gpio_in_capture_pkg
`default_nettype wire

// File: rtl/gpio_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_debounce
//  Description : Single-bit debouncer. The output follows the (already
//                synchronised) input only after the input has disagreed with
//                it for db_count+1 consecutive cycles; any return to the
//                current output value restarts the count.
//  Ports       : clk, reset (sync, active-high), in (synchronised pin),
//                db_count[DB_W] (stable time), out (debounced level)
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_debounce
    import gpio_in_capture_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    in,
    input  db_cnt_t db_count,
    output logic    out
);

    db_cnt_t r_cnt;

    // The >= compare (rather than ==) keeps the counter from wrapping if
    // db_count is lowered below the running count mid-way: the next
    // mismatch cycle commits the new level instead.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            out   <= 1'b0;
        end else if (in == out) begin
            r_cnt <= '0;
        end else if (r_cnt >= db_count) begin
            out   <= in;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule : gpio_debounce
`default_nettype wire

// File: rtl/setting_reg.sv
`default_nettype none
// ============================================================================
//  Module      : setting_reg
//  Description : Single settings-bus register. Captures the write data when
//                the strobe is asserted at its own address; the new value is
//                visible the cycle after the strobe.
//  Ports       : clk, reset (sync, active-high), strobe, addr[AWIDTH],
//                in[WIDTH] (write data), out[WIDTH] (register value)
//  Revision    : 1.0 - initial release
// ============================================================================
module setting_reg #(
    parameter int               MY_ADDR  = 0,
    parameter int               AWIDTH   = 8,
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] AT_RESET = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              strobe,
    input  logic [AWIDTH-1:0] addr,
    input  logic [WIDTH-1:0]  in,
    output logic [WIDTH-1:0]  out
);

    localparam logic [AWIDTH-1:0] c_my_addr = AWIDTH'(MY_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= AT_RESET;
        end else if (strobe && (addr == c_my_addr)) begin
            out <= in;
        end
    end

endmodule : setting_reg
`default_nettype wire

// File: rtl/gpio_in_capture.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_in_capture
//  Description : GPIO input capture. Synchronises the daughterboard pins,
//                debounces each bit, latches masked rising/falling edges into
//                sticky event flags and raises irq while any flag is pending.
//                Register map (settings bus):
//                  BASE+0 rise_mask, BASE+1 fall_mask, BASE+2 db_count[15:0],
//                  BASE+3 event clear (write-1-to-clear, no storage)
//  Ports       : clk, reset (sync, active-high)
//                set_stb, set_addr[8], set_data[32]   settings bus
//                gpio_in[WIDTH]                        asynchronous pins
//                gpio_state_rb[32]                     debounced state
//                gpio_event_rb[32]                     sticky event flags
//                irq                                   any event pending
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_in_capture
    import gpio_in_capture_pkg::*;
#(
    parameter int BASE  = 0,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [31:0]      gpio_state_rb,
    output logic [31:0]      gpio_event_rb,
    output logic             irq
);

    localparam logic [7:0] c_addr_clr = reg_addr(BASE, GPIO_IN_CLR);

    logic [WIDTH-1:0] w_rise_mask;
    logic [WIDTH-1:0] w_fall_mask;
    db_cnt_t          w_db_count;
    logic [WIDTH-1:0] w_deb;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_clr;

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_deb_q;
    logic [WIDTH-1:0] r_ev;

    // Write-data bits above WIDTH (and above the debounce width) carry no
    // meaning for this block.
    logic w_unused_set_data;
    assign w_unused_set_data = ^set_data;

    // ------------------------------------------------------------------
    // Settings registers
    // ------------------------------------------------------------------
    setting_reg #(
        .MY_ADDR (BASE + GPIO_IN_RISE),
        .AWIDTH  (8),
        .WIDTH   (WIDTH)
    ) u_rise_mask (
        .clk    (clk),
        .reset  (reset),
        .strobe (set_stb),
        .addr   (set_addr),
        .in     (set_data[WIDTH-1:0]),
        .out    (w_rise_mask)
    );

    setting_reg #(
        .MY_ADDR (BASE + GPIO_IN_FALL),
        .AWIDTH  (8),
        .WIDTH   (WIDTH)
    ) u_fall_mask (
        .clk    (clk),
        .reset  (reset),
        .strobe (set_stb),
        .addr   (set_addr),
        .in     (set_data[WIDTH-1:0]),
        .out    (w_fall_mask)
    );

    setting_reg #(
        .MY_ADDR (BASE + GPIO_IN_DB),
        .AWIDTH  (8),
        .WIDTH   (DB_W)
    ) u_db_count (
        .clk    (clk),
        .reset  (reset),
        .strobe (set_stb),
        .addr   (set_addr),
        .in     (set_data[DB_W-1:0]),
        .out    (w_db_count)
    );

    // ------------------------------------------------------------------
    // Per-bit debouncers, fed from the second synchroniser stage
    // ------------------------------------------------------------------
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_debounce u_debounce (
            .clk      (clk),
            .reset    (reset),
            .in       (r_s2[i]),
            .db_count (w_db_count),
            .out      (w_deb[i])
        );
    end

    // ------------------------------------------------------------------
    // Edge detection and clear decode
    // ------------------------------------------------------------------
    assign w_rise = w_deb & ~r_deb_q & w_rise_mask;
    assign w_fall = ~w_deb & r_deb_q & w_fall_mask;
    assign w_clr  = (set_stb && (set_addr == c_addr_clr)) ? set_data[WIDTH-1:0]
                                                           : '0;

    // ------------------------------------------------------------------
    // Synchroniser, event flags and registered readback
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1          <= '0;
            r_s2          <= '0;
            r_deb_q       <= '0;
            r_ev          <= '0;
            gpio_state_rb <= '0;
            gpio_event_rb <= '0;
            irq           <= 1'b0;
        end else begin
            r_s1          <= gpio_in;
            r_s2          <= r_s1;
            r_deb_q       <= w_deb;
            // A new edge in the same cycle as its clear keeps the flag set.
            r_ev          <= (r_ev & ~w_clr) | w_rise | w_fall;
            gpio_state_rb <= 32'(w_deb);
            gpio_event_rb <= 32'(r_ev);
            irq           <= |r_ev;
        end
    end

endmodule : gpio_in_capture
`default_nettype wire
